// File: rtl/if_stage.sv
// if_stage: PC generation, ROM enable and IF/ID pipeline register with stall, flush and redirect handling
module if_stage #(
  parameter int ADDR_W = 32,
  parameter int INST_W = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = 32'h00000000,
  parameter logic [INST_W-1:0] NOP_INST = 32'h00000013
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stall_if,
  input  logic              stall_id,
  input  logic              flush,
  input  logic              branch_flag_i,
  input  logic [ADDR_W-1:0] branch_target_i,
  input  logic [INST_W-1:0] rom_inst_i,
  output logic [ADDR_W-1:0] pc_o,
  output logic              ce_o,
  output logic [ADDR_W-1:0] id_pc_o,
  output logic [INST_W-1:0] id_inst_o,
  output logic              id_valid_o
);
  logic bubble;
  logic [ADDR_W-1:0] pc_next;
  always_comb begin
    bubble  = flush || (!stall_id && (stall_if || !ce_o || branch_flag_i));
    pc_next = branch_flag_i ? {branch_target_i[ADDR_W-1:2], 2'b00} : pc_o + ADDR_W'(4);
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      ce_o       <= 1'b0;
      pc_o       <= RESET_PC;
      id_pc_o    <= '0;
      id_inst_o  <= NOP_INST;
      id_valid_o <= 1'b0;
    end else begin
      ce_o <= 1'b1;
      if (ce_o && !stall_if) pc_o <= pc_next;
      if (bubble) begin
        id_pc_o    <= '0;
        id_inst_o  <= NOP_INST;
        id_valid_o <= 1'b0;
      end else if (!stall_id) begin
        id_pc_o    <= pc_o;
        id_inst_o  <= rom_inst_i;
        id_valid_o <= 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_if_stage.sv
// tb_if_stage: directed and random checks of if_stage against a cycle-level reference model
module tb_if_stage;
  logic        clk = 1'b0;
  logic        rst, stall_if, stall_id, flush, branch_flag_i;
  logic [31:0] branch_target_i, rom_inst_i, pc_o, id_pc_o, id_inst_o;
  logic        ce_o, id_valid_o;
  int n_chk = 0;
  int n_fail = 0;
  logic        m_ce, m_valid;
  logic [31:0] m_pc, m_id_pc, m_id_inst;

  if_stage dut (
    .clk(clk), .rst(rst), .stall_if(stall_if), .stall_id(stall_id), .flush(flush),
    .branch_flag_i(branch_flag_i), .branch_target_i(branch_target_i), .rom_inst_i(rom_inst_i),
    .pc_o(pc_o), .ce_o(ce_o), .id_pc_o(id_pc_o), .id_inst_o(id_inst_o), .id_valid_o(id_valid_o)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] rom(input logic [31:0] a);
    return a == 32'h0 ? 32'h00100093 : a == 32'h4 ? 32'h00200113 : (a * 32'h9E3779B1) ^ 32'h13;
  endfunction

  assign rom_inst_i = rom(pc_o);

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_model();
    chk("model ce_o", {31'b0, ce_o}, {31'b0, m_ce});
    chk("model pc_o", pc_o, m_pc);
    chk("model id_pc_o", id_pc_o, m_id_pc);
    chk("model id_inst_o", id_inst_o, m_id_inst);
    chk("model id_valid_o", {31'b0, id_valid_o}, {31'b0, m_valid});
  endtask

  // One clock: apply inputs, advance the reference model by the fetch rules, then compare.
  task automatic cyc(input logic r, input logic si, input logic sd, input logic fl,
                     input logic br, input logic [31:0] tgt);
    logic [31:0] fetched;
    rst = r; stall_if = si; stall_id = sd; flush = fl; branch_flag_i = br; branch_target_i = tgt;
    @(posedge clk);
    fetched = rom(m_pc);
    if (r) begin
      m_ce = 0; m_pc = 0; m_id_pc = 0; m_id_inst = 32'h13; m_valid = 0;
    end else begin
      if (fl) begin
        m_id_pc = 0; m_id_inst = 32'h13; m_valid = 0;
      end else if (!sd) begin
        if (si || !m_ce || br) begin
          m_id_pc = 0; m_id_inst = 32'h13; m_valid = 0;
        end else begin
          m_id_pc = m_pc; m_id_inst = fetched; m_valid = 1;
        end
      end
      if (m_ce && !si) m_pc = br ? tgt - (tgt % 4) : m_pc + 4;
      m_ce = 1;
    end
    #1;
    check_model();
  endtask

  initial begin
    cyc(1, 0, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 0, 0);
    chk("reset ce_o", {31'b0, ce_o}, 32'h0);
    chk("reset pc_o", pc_o, 32'h0);
    chk("reset id_valid_o", {31'b0, id_valid_o}, 32'h0);
    chk("reset id_inst_o", id_inst_o, 32'h13);
    cyc(0, 0, 0, 0, 0, 0);
    chk("start ce_o", {31'b0, ce_o}, 32'h1);
    chk("start pc_o", pc_o, 32'h0);
    cyc(0, 0, 0, 0, 0, 0);
    chk("edge2 pc_o", pc_o, 32'h4);
    chk("edge2 id_pc_o", id_pc_o, 32'h0);
    chk("edge2 id_inst_o", id_inst_o, 32'h00100093);
    chk("edge2 id_valid_o", {31'b0, id_valid_o}, 32'h1);
    cyc(0, 0, 0, 0, 0, 0);
    chk("edge3 id_pc_o", id_pc_o, 32'h4);
    chk("edge3 id_inst_o", id_inst_o, 32'h00200113);
    cyc(0, 0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 0);
    chk("seq pc_o", pc_o, 32'h10);
    chk("seq id_pc_o lag", id_pc_o, 32'hC);
    cyc(0, 0, 0, 0, 1, 32'h102);
    chk("branch pc_o", pc_o, 32'h100);
    chk("branch bubble valid", {31'b0, id_valid_o}, 32'h0);
    chk("branch bubble inst", id_inst_o, 32'h13);
    cyc(0, 0, 0, 0, 0, 0);
    chk("after branch id_pc_o", id_pc_o, 32'h100);
    chk("after branch id_valid_o", {31'b0, id_valid_o}, 32'h1);
    cyc(0, 0, 0, 0, 1, 32'h20);
    cyc(0, 1, 0, 0, 0, 0);
    cyc(0, 1, 0, 0, 0, 0);
    chk("stall_if pc_o", pc_o, 32'h20);
    chk("stall_if bubble", {31'b0, id_valid_o}, 32'h0);
    cyc(0, 0, 0, 0, 0, 0);
    chk("resume id_pc_o", id_pc_o, 32'h20);
    chk("resume pc_o", pc_o, 32'h24);
    cyc(0, 1, 1, 0, 0, 0);
    cyc(0, 1, 1, 0, 0, 0);
    chk("stall both pc_o", pc_o, 32'h24);
    chk("stall both id_pc_o", id_pc_o, 32'h20);
    chk("stall both id_valid_o", {31'b0, id_valid_o}, 32'h1);
    cyc(0, 1, 0, 0, 1, 32'h300);
    chk("branch during stall_if pc_o", pc_o, 32'h24);
    cyc(0, 0, 0, 0, 0, 0);
    cyc(0, 0, 1, 1, 0, 0);
    chk("flush id_valid_o", {31'b0, id_valid_o}, 32'h0);
    chk("flush id_pc_o", id_pc_o, 32'h0);
    chk("flush id_inst_o", id_inst_o, 32'h13);
    chk("flush pc_o", pc_o, 32'h2C);
    cyc(0, 0, 0, 0, 1, 32'hFFFFFFFF);
    chk("wrap target", pc_o, 32'hFFFFFFFC);
    cyc(0, 0, 0, 0, 0, 0);
    chk("wrap pc_o", pc_o, 32'h0);
    cyc(0, 0, 0, 1, 1, 32'h40);
    chk("flush+branch pc_o", pc_o, 32'h40);
    cyc(1, 0, 0, 0, 0, 0);
    chk("midrun rst pc_o", pc_o, 32'h0);
    chk("midrun rst ce_o", {31'b0, ce_o}, 32'h0);
    chk("midrun rst id_valid_o", {31'b0, id_valid_o}, 32'h0);
    for (int i = 0; i < 400; i++)
      cyc($urandom_range(0, 39) == 0, $urandom_range(0, 4) == 0, $urandom_range(0, 4) == 0,
          $urandom_range(0, 9) == 0, $urandom_range(0, 5) == 0, $urandom);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
